// File: rtl/hazard_forward_ctrl.sv
// rtl/hazard_forward_ctrl.sv - operand bypass select and counted load-use stall control
// Optional statistics counters built only when HAZARD_STATS_EN is defined.
module hazard_forward_ctrl #(
  parameter int NUM_SRC    = 2,
  parameter int NUM_FWD    = 2,
  parameter int REG_AW     = 5,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16,
  localparam int SEL_W     = $clog2(NUM_FWD + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*REG_AW-1:0] src_rr_ex,
  input  logic [NUM_FWD*REG_AW-1:0] dstn_fwd,
  input  logic [NUM_FWD-1:0]        RegWrite_fwd,
  input  logic [NUM_SRC*REG_AW-1:0] src_id_rr,
  input  logic [NUM_SRC-1:0]        src_id_rr_vld,
  input  logic [REG_AW-1:0]         dstn_rr_ex,
  input  logic                      RegWrite_rr_ex,
  input  logic                      MemRead_rr_ex,
  input  logic                      flush,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic                      stall,
  output logic                      bubble,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          fwd_cnt
);

  typedef enum logic {IDLE, STALL} state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        src_match;
  logic        hz;

  // Scan oldest to youngest so the youngest matching stage overwrites last.
  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
        if (RegWrite_fwd[k] &&
            dstn_fwd[k*REG_AW +: REG_AW] != '0 &&
            dstn_fwd[k*REG_AW +: REG_AW] == src_rr_ex[i*REG_AW +: REG_AW])
          fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
      end
    end
  end

  always_comb begin
    src_match = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_id_rr_vld[i] && src_id_rr[i*REG_AW +: REG_AW] == dstn_rr_ex)
        src_match = 1'b1;
    end
  end

  assign hz = MemRead_rr_ex & RegWrite_rr_ex & (dstn_rr_ex != '0) & src_match;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // The detection cycle is the first stall cycle, so STALL covers LOAD_STALL-1 more.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    stall   = 1'b0;
    case (state)
      IDLE: begin
        if (hz && !flush) begin
          stall = 1'b1;
          if (LOAD_STALL > 1) begin
            state_n = STALL;
            cnt_n   = 4'(LOAD_STALL - 1);
          end
        end
      end
      STALL: begin
        if (flush) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          stall = 1'b1;
          if (cnt == 4'd1) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt - 4'd1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
    if (!rst_n)
      stall = 1'b0;
  end

  assign bubble = stall;

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if ((|fwd_sel) && fwd_cnt != '1)
        fwd_cnt <= fwd_cnt + CNT_W'(1);
    end
  end
`else
  assign stall_cnt = '0;
  assign fwd_cnt   = '0;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb/tb_hazard_forward_ctrl.sv - directed and randomized bench against a cycle-level forwarding/stall model
// Three instances share the inputs with LOAD_STALL = 1, 2, 3; HAZARD_STATS_EN selects counter expectations.
module tb_hazard_forward_ctrl;

  localparam int NS = 2;
  localparam int NF = 2;
  localparam int AW = 5;
  localparam int SW = 2;
  localparam int CW = 4;
  localparam int NI = 3;
`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic [NS*AW-1:0]   src_rr_ex;
  logic [NF*AW-1:0]   dstn_fwd;
  logic [NF-1:0]      RegWrite_fwd;
  logic [NS*AW-1:0]   src_id_rr;
  logic [NS-1:0]      src_id_rr_vld;
  logic [AW-1:0]      dstn_rr_ex;
  logic               RegWrite_rr_ex;
  logic               MemRead_rr_ex;
  logic               flush;

  logic [NS*SW-1:0]   fwd_sel_o [NI];
  logic               stall_o   [NI];
  logic               bubble_o  [NI];
  logic [CW-1:0]      scnt_o    [NI];
  logic [CW-1:0]      fcnt_o    [NI];

  int n_cmp = 0;
  int n_err = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    hazard_forward_ctrl #(
      .NUM_SRC(NS), .NUM_FWD(NF), .REG_AW(AW), .LOAD_STALL(g + 1), .CNT_W(CW)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .src_rr_ex(src_rr_ex), .dstn_fwd(dstn_fwd), .RegWrite_fwd(RegWrite_fwd),
      .src_id_rr(src_id_rr), .src_id_rr_vld(src_id_rr_vld),
      .dstn_rr_ex(dstn_rr_ex), .RegWrite_rr_ex(RegWrite_rr_ex), .MemRead_rr_ex(MemRead_rr_ex),
      .flush(flush),
      .fwd_sel(fwd_sel_o[g]), .stall(stall_o[g]), .bubble(bubble_o[g]),
      .stall_cnt(scnt_o[g]), .fwd_cnt(fcnt_o[g])
    );
  end

  // Reference model: remaining stall cycles per instance and unbounded event counts.
  int rem    [NI] = '{default: 0};
  int m_scnt [NI] = '{default: 0};
  int m_fcnt      = 0;

  function automatic int exp_sel(int i);
    logic [AW-1:0] s, d;
    s = src_rr_ex[i*AW +: AW];
    for (int k = 0; k < NF; k++) begin
      d = dstn_fwd[k*AW +: AW];
      if (RegWrite_fwd[k] && d != 0 && d == s) return k + 1;
    end
    return 0;
  endfunction

  function automatic logic [NS*SW-1:0] exp_sel_all();
    logic [NS*SW-1:0] v;
    for (int i = 0; i < NS; i++) v[i*SW +: SW] = SW'(exp_sel(i));
    return v;
  endfunction

  function automatic bit exp_hz();
    if (!(MemRead_rr_ex && RegWrite_rr_ex && dstn_rr_ex != 0)) return 1'b0;
    for (int i = 0; i < NS; i++)
      if (src_id_rr_vld[i] && src_id_rr[i*AW +: AW] == dstn_rr_ex) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_stall(int g);
    return rst_n && !flush && (rem[g] > 0 || exp_hz());
  endfunction

  function automatic int exp_cnt(int v);
    if (!STATS) return 0;
    return (v > 15) ? 15 : v;
  endfunction

  always @(posedge clk) begin
    bit st [NI];
    bit any_f;
    bit h;
    any_f = (exp_sel_all() != 0);
    h = exp_hz();
    for (int g = 0; g < NI; g++) st[g] = exp_stall(g);
    if (!rst_n) m_fcnt = 0;
    else if (any_f) m_fcnt++;
    for (int g = 0; g < NI; g++) begin
      if (!rst_n) m_scnt[g] = 0;
      else if (st[g]) m_scnt[g]++;
      if (!rst_n || flush) rem[g] = 0;
      else if (rem[g] > 0) rem[g]--;
      else if (h) rem[g] = g;
    end
  end

  task automatic clear_inputs();
    src_rr_ex = '0; dstn_fwd = '0; RegWrite_fwd = '0;
    src_id_rr = '0; src_id_rr_vld = '0; dstn_rr_ex = '0;
    RegWrite_rr_ex = 1'b0; MemRead_rr_ex = 1'b0; flush = 1'b0;
  endtask

  task automatic set_hz(input logic [NS-1:0] vld);
    MemRead_rr_ex = 1'b1; RegWrite_rr_ex = 1'b1; dstn_rr_ex = 5'd8;
    src_id_rr = {5'd8, 5'd2}; src_id_rr_vld = vld;
  endtask

  task automatic settle();
    repeat (4) begin @(negedge clk); clear_inputs(); rst_n = 1'b1; end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    set_hz(2'b11);
    src_rr_ex = {5'd0, 5'd3}; dstn_fwd = {5'd0, 5'd3}; RegWrite_fwd = 2'b01;
    repeat (3) @(negedge clk);
    #2;
    for (int g = 0; g < NI; g++) begin
      n_cmp++; if (stall_o[g] !== 1'b0) begin n_err++; $display("FAIL reset_stall g%0d: got %b expected 0", g, stall_o[g]); end
      n_cmp++; if (bubble_o[g] !== 1'b0) begin n_err++; $display("FAIL reset_bubble g%0d: got %b expected 0", g, bubble_o[g]); end
      n_cmp++; if (scnt_o[g] !== 4'd0) begin n_err++; $display("FAIL reset_stall_cnt g%0d: got %0d expected 0", g, scnt_o[g]); end
      n_cmp++; if (fcnt_o[g] !== 4'd0) begin n_err++; $display("FAIL reset_fwd_cnt g%0d: got %0d expected 0", g, fcnt_o[g]); end
      n_cmp++; if (fwd_sel_o[g] !== 4'b0001) begin n_err++; $display("FAIL reset_fwd_sel g%0d: got %b expected 0001", g, fwd_sel_o[g]); end
    end
  endtask

  task automatic test_priority();
    settle();
    @(negedge clk);
    src_rr_ex = {5'd0, 5'd5}; dstn_fwd = {5'd5, 5'd5}; RegWrite_fwd = 2'b11;
    #2;
    n_cmp++; if (fwd_sel_o[0][1:0] !== 2'd1) begin n_err++; $display("FAIL prio_youngest: got %0d expected 1", fwd_sel_o[0][1:0]); end
    RegWrite_fwd = 2'b10;
    #2;
    n_cmp++; if (fwd_sel_o[0][1:0] !== 2'd2) begin n_err++; $display("FAIL prio_older: got %0d expected 2", fwd_sel_o[0][1:0]); end
    src_rr_ex = '0; dstn_fwd = '0; RegWrite_fwd = 2'b11;
    #2;
    n_cmp++; if (fwd_sel_o[1] !== 4'b0000) begin n_err++; $display("FAIL reg0_never: got %b expected 0000", fwd_sel_o[1]); end
    src_rr_ex = {5'd7, 5'd0}; dstn_fwd = {5'd0, 5'd7}; RegWrite_fwd = 2'b01;
    #2;
    n_cmp++; if (fwd_sel_o[2] !== 4'b0100) begin n_err++; $display("FAIL enable_qual: got %b expected 0100", fwd_sel_o[2]); end
  endtask

  task automatic test_load_use();
    settle();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      clear_inputs();
      if (c == 0) set_hz(2'b10);
      #2;
      for (int g = 0; g < NI; g++) begin
        n_cmp++;
        if (stall_o[g] !== (c <= g)) begin
          n_err++; $display("FAIL load_use_len g%0d c%0d: got %b expected %b", g, c, stall_o[g], (c <= g));
        end
      end
    end
    @(negedge clk);
    set_hz(2'b01);
    #2;
    for (int g = 0; g < NI; g++) begin
      n_cmp++; if (stall_o[g] !== 1'b0) begin n_err++; $display("FAIL unread_operand g%0d: got %b expected 0", g, stall_o[g]); end
    end
  endtask

  task automatic test_flush();
    settle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      clear_inputs();
      if (c <= 1) set_hz(2'b10);
      if (c == 1) flush = 1'b1;
      #2;
      for (int g = 0; g < NI; g++) begin
        n_cmp++;
        if (stall_o[g] !== (c == 0) || bubble_o[g] !== (c == 0)) begin
          n_err++; $display("FAIL flush_abort g%0d c%0d: got %b expected %b", g, c, stall_o[g], (c == 0));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    settle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      clear_inputs();
      rst_n = (c != 1);
      if (c == 0) set_hz(2'b10);
      #2;
      for (int g = 0; g < NI; g++) begin
        n_cmp++;
        if (stall_o[g] !== (c == 0)) begin
          n_err++; $display("FAIL reset_mid g%0d c%0d: got %b expected %b", g, c, stall_o[g], (c == 0));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int seen;
    seen = 0;
    @(negedge clk); clear_inputs(); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c != 0) @(negedge clk);
      clear_inputs();
      if (c == 0 || c == 2) set_hz(2'b10);
      #2;
      if (stall_o[1] === 1'b1) seen++;
    end
    @(negedge clk); #2;
    n_cmp++; if (seen != 4) begin n_err++; $display("FAIL b2b_cycles: got %0d expected 4", seen); end
    n_cmp++;
    if (scnt_o[1] !== 4'(STATS ? 4 : 0)) begin
      n_err++; $display("FAIL b2b_stall_cnt: got %0d expected %0d", scnt_o[1], STATS ? 4 : 0);
    end
  endtask

  task automatic test_saturation();
    @(negedge clk); clear_inputs(); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    src_rr_ex = {5'd0, 5'd9}; dstn_fwd = {5'd9, 5'd0}; RegWrite_fwd = 2'b10;
    repeat (20) @(negedge clk);
    #2;
    for (int g = 0; g < NI; g++) begin
      n_cmp++;
      if (fcnt_o[g] !== 4'(STATS ? 15 : 0)) begin
        n_err++; $display("FAIL fwd_cnt_sat g%0d: got %0d expected %0d", g, fcnt_o[g], STATS ? 15 : 0);
      end
    end
    repeat (3) @(negedge clk);
    #2;
    n_cmp++;
    if (fcnt_o[0] !== 4'(STATS ? 15 : 0)) begin
      n_err++; $display("FAIL fwd_cnt_hold: got %0d expected %0d", fcnt_o[0], STATS ? 15 : 0);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 29) != 0);
      flush = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < NS; i++) begin
        src_rr_ex[i*AW +: AW] = AW'($urandom_range(0, 3));
        src_id_rr[i*AW +: AW] = AW'($urandom_range(0, 3));
      end
      for (int k = 0; k < NF; k++) dstn_fwd[k*AW +: AW] = AW'($urandom_range(0, 3));
      RegWrite_fwd   = NF'($urandom_range(0, 3));
      src_id_rr_vld  = NS'($urandom_range(0, 3));
      dstn_rr_ex     = AW'($urandom_range(0, 3));
      RegWrite_rr_ex = ($urandom_range(0, 3) != 0);
      MemRead_rr_ex  = $urandom_range(0, 1) != 0;
      #2;
      for (int g = 0; g < NI; g++) begin
        n_cmp++;
        if (fwd_sel_o[g] !== exp_sel_all()) begin
          n_err++; $display("FAIL rnd_fwd_sel g%0d n%0d: got %b expected %b", g, n, fwd_sel_o[g], exp_sel_all());
        end
        n_cmp++;
        if (stall_o[g] !== exp_stall(g) || bubble_o[g] !== exp_stall(g)) begin
          n_err++; $display("FAIL rnd_stall g%0d n%0d: got %b/%b expected %b", g, n, stall_o[g], bubble_o[g], exp_stall(g));
        end
        n_cmp++;
        if (scnt_o[g] !== 4'(exp_cnt(m_scnt[g])) || fcnt_o[g] !== 4'(exp_cnt(m_fcnt))) begin
          n_err++; $display("FAIL rnd_counters g%0d n%0d: got %0d/%0d expected %0d/%0d", g, n,
                            scnt_o[g], fcnt_o[g], exp_cnt(m_scnt[g]), exp_cnt(m_fcnt));
        end
      end
    end
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_priority();
    test_load_use();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
